modred_issue_ctrl: RTL
======================

Name: modred_issue_ctrl

Overview:
- Initiator-side controller for the serial shift-add modular reducer (start/x/m/m_bl in, result/valid out).
- Buffers incoming 64-bit operands, latches the modulus and derives its bit length, issues one reduction at a time, and returns results in order on a valid/ready stream.
- Sits between the operand producer and the reducer instance; the reducer is instantiated outside this block.

Parameters:
- XW, 64, operand/result width.
- MW, 32, modulus width.
- FIFO_DEPTH, 4, input operand FIFO entries (power of two, >=2).
- TIMEOUT_CYC, 256, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cfg_we_i  in  1  modulus write strobe.
- cfg_m_i  in  MW  modulus value.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  operand ready.
- in_x_i  in  XW  operand x.
- red_start_o  out  1  one-cycle start pulse to the reducer.
- red_x_o  out  XW  operand to the reducer, held stable from the start pulse until capture.
- red_m_o  out  MW  latched modulus.
- red_m_bl_o  out  MW  ceil(log2(m)) of the latched modulus.
- red_valid_i  in  1  reducer result valid.
- red_result_i  in  XW  reducer result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result ready.
- out_data_o  out  XW  x mod m.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO is empty, FSM is IDLE, m_valid=0, red_m_o=0, red_m_bl_o=0, err_o=0.
  - Reset mid-operation abandons the current job silently, with no start pulse or output afterwards.
- Config:
  - cfg_we_i is accepted only when FSM=IDLE and the FIFO is empty.
  - On acceptance, red_m_o<=cfg_m_i, red_m_bl_o<=ceil(log2(cfg_m_i)), m_valid<=1.
  - ceil(log2(1))=0; for example 0x7FFFFF gives 23 and 0x80000001 gives 32.
  - If cfg_m_i==0, or the write arrives while busy, the write is dropped and err_o<=1.
- Input FIFO:
  - in_ready_o = (count<FIFO_DEPTH), registered count only; there is no push-through when full, even on a same-cycle pop.
  - Push on in_valid_i&&in_ready_o.
  - Operands accumulate while m_valid=0.
- FSM, IDLE:
  - If m_valid and the FIFO is non-empty: pop into x_reg.
  - If x_reg<m (compared against the popped value): go to HOLD with out_data_o<=x (bypass, no start pulse).
  - Otherwise: go to ISSUE.
- FSM, ISSUE:
  - red_start_o=1 for exactly this cycle; red_x_o=x_reg; go to WAIT.
- FSM, WAIT:
  - Capture on a rising edge of red_valid_i (red_valid_i=1 and the registered previous value=0), so a level left high from the prior job is ignored.
  - On capture: out_data_o<=red_result_i; go to HOLD.
- FSM, HOLD:
  - out_valid_o=1 with out_data_o stable until out_ready_i is high; on that handshake go to IDLE.
- Latency:
  - Bypass: operand accepted at cycle 0, out_valid_o high at cycle 2.
  - Reduction: start pulse at cycle 2; out_valid_o high one cycle after the red_valid_i rising edge.
- Ordering and width:
  - Results leave in acceptance order; at most one job is outstanding at the reducer.
  - x_reg<m compares the zero-extended m at XW bits.
- err_o is cleared only by reset.

Optional Feature:
- Macro: MODRED_TIMEOUT_EN.
- With the macro defined:
  - A WAIT counter starts at 0 on entry.
  - If it reaches TIMEOUT_CYC without capture: err_o<=1, the job is dropped with no output, and the FSM returns to IDLE.
  - A late red_valid_i rising edge that arrives outside WAIT is ignored.
- Without the macro: WAIT has no limit, no counter logic is present, and err_o is set only by the config conditions.

Test Plan:
- Modulus bit length: config m=0x7FFFFF -> red_m_bl_o=23; then m=0x80000001 -> 32; then m=1 -> 0; then m=0 -> err_o=1 and red_m_bl_o stays 0.
- Reduction path: m=0x7FFFFF with a 5-cycle reducer stub; push x=0x1800002 -> one start pulse with red_x_o=0x1800002; out_data_o=0x5 one cycle after stub valid rises; push x=0x800000 -> out_data_o=0x1.
- Bypass: m=0x7FFFFF; push x=0x7FFFFE at cycle 0 -> out_valid_o=1 and out_data_o=0x7FFFFE at cycle 2; red_start_o never asserts.
- Backpressure: out_ready_i=0; offer 6 operands back-to-back -> 5 accepted (1 in HOLD, 4 in FIFO); in_ready_o=0 afterwards; release out_ready_i -> all results in order.
- Config while busy or reset mid-WAIT:
  - cfg_we_i during WAIT -> err_o=1 and red_m_o unchanged.
  - rst_i during WAIT -> next cycle all outputs 0, and no out_valid_o when the stub valid rises later.
- Timeout (MODRED_TIMEOUT_EN, TIMEOUT_CYC=256): stub never asserts valid -> err_o=1 after 256 WAIT cycles with no output; the next queued operand issues normally.

Source files
------------

// File: rtl/modred_issue_ctrl.sv
// -----------------------------------------------------------------------------
// modred_issue_ctrl
// Initiator-side controller for a serial shift-add modular reducer. Buffers
// incoming operands in a small FIFO, latches the modulus and its bit length,
// issues one reduction at a time (bypassing operands already below m) and
// returns x mod m in acceptance order on a valid/ready stream.
//
// Optional feature macro: MODRED_TIMEOUT_EN
//   When defined, a WAIT-state watchdog drops a job that gets no reducer
//   result within TIMEOUT_CYC cycles and raises err_o.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cfg_we_i, cfg_m_i         modulus write (accepted only when idle and empty)
//   in_valid_i/in_ready_o     operand stream, in_x_i operand
//   red_start_o, red_x_o      start pulse and operand to the reducer
//   red_m_o, red_m_bl_o       latched modulus and ceil(log2(m))
//   red_valid_i, red_result_i reducer result (captured on rising edge of valid)
//   out_valid_o/out_ready_i   result stream, out_data_o = x mod m
//   busy_o                    FSM not idle or FIFO non-empty
//   err_o                     sticky error flag (cleared only by reset)
// -----------------------------------------------------------------------------
module modred_issue_ctrl #(
   parameter int unsigned XW          = 64,
   parameter int unsigned MW          = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cfg_we_i,
   input  logic [MW-1:0] cfg_m_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [XW-1:0] in_x_i,
   output logic          red_start_o,
   output logic [XW-1:0] red_x_o,
   output logic [MW-1:0] red_m_o,
   output logic [MW-1:0] red_m_bl_o,
   input  logic          red_valid_i,
   input  logic [XW-1:0] red_result_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [XW-1:0] out_data_o,
   output logic          busy_o,
   output logic          err_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

   state_t        state, state_d;
   logic [XW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_d;
   logic [XW-1:0] head;
   logic [XW-1:0] x_reg, out_data;
   logic [MW-1:0] m_reg, m_bl;
   logic          m_valid;
   logic          push, pop, bypass, cap_en, timeout, timeout_hit;
   logic          cfg_ok, cfg_bad;
   logic          start_q, out_valid_q, in_ready_q, err_q, red_valid_q;

   // ceil(log2(v)) equals the bit length of (v - 1); v = 1 gives 0
   function automatic logic [MW-1:0] ceil_log2(input logic [MW-1:0] v);
      logic [MW-1:0] t;
      logic [MW-1:0] bl;
      t  = v - MW'(1);
      bl = '0;
      for (int i = 0; i < int'(MW); i++) begin
         if (t != '0) begin
            bl = bl + MW'(1);
            t  = t >> 1;
         end
      end
      return bl;
   endfunction

   assign head    = mem[rd_ptr];
   assign push    = in_valid_i && in_ready_q;
   assign count_d = count + CW'(push) - CW'(pop);
   assign cfg_ok  = cfg_we_i && (state == S_IDLE) && (count == '0) && (cfg_m_i != '0);
   assign cfg_bad = cfg_we_i && !cfg_ok;

`ifdef MODRED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wait_cnt;

   // Counts cycles spent in WAIT; zero on the first WAIT cycle
   always_ff @(posedge clk_i) begin
      if (rst_i || state != S_WAIT) wait_cnt <= '0;
      else                          wait_cnt <= wait_cnt + TW'(1);
   end

   assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout_hit    = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_d;
   end

   // Next-state and datapath enables
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      bypass  = 1'b0;
      cap_en  = 1'b0;
      timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (m_valid && count != '0) begin
               pop = 1'b1;
               // Operands already below m need no reduction
               if (head < XW'(m_reg)) begin
                  bypass  = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // Rising edge only: a level left high by the previous job is ignored
            if (red_valid_i && !red_valid_q) begin
               cap_en  = 1'b1;
               state_d = S_HOLD;
            end else if (timeout_hit) begin
               timeout = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO storage needs no reset; only pointers and count define occupancy
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= in_x_i;
   end

   // Pointers, operand/result registers, config and flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         in_ready_q  <= 1'b0;
         x_reg       <= '0;
         out_data    <= '0;
         m_reg       <= '0;
         m_bl        <= '0;
         m_valid     <= 1'b0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         red_valid_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            x_reg  <= head;
         end
         count       <= count_d;
         // Registered copy of (count < FIFO_DEPTH); held low during reset
         in_ready_q  <= (count_d < CW'(FIFO_DEPTH));
         if (bypass)      out_data <= head;
         else if (cap_en) out_data <= red_result_i;
         start_q     <= (state_d == S_ISSUE);
         out_valid_q <= (state_d == S_HOLD);
         red_valid_q <= red_valid_i;
         if (cfg_ok) begin
            m_reg   <= cfg_m_i;
            m_bl    <= ceil_log2(cfg_m_i);
            m_valid <= 1'b1;
         end
         if (cfg_bad || timeout) err_q <= 1'b1;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign red_start_o = start_q;
   assign red_x_o     = x_reg;
   assign red_m_o     = m_reg;
   assign red_m_bl_o  = m_bl;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data;
   assign busy_o      = (state != S_IDLE) || (count != '0);
   assign err_o       = err_q;

endmodule
